// File: rtl/instr_issue_ctrl.sv
// Decode/issue controller for a 6-bit ADD/SUB ALU: one instruction in flight, accept->retire 3 cycles, instr_ready only in IDLE.
// DBG_READ_EN adds a combinational register-file read port (dbg_sel/dbg_data).
module instr_issue_ctrl #(
    parameter int NREG   = 4,
    parameter int REG_W  = 8,
    parameter int OPND_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [16:0]             instr,
    output logic [OPND_W-1:0]       alu_a,
    output logic [OPND_W-1:0]       alu_b,
    output logic [2:0]              alu_opcode,
    input  logic [REG_W-1:0]        alu_res,
    output logic                    res_valid,
    output logic [REG_W-1:0]        res_data,
    output logic [$clog2(NREG)-1:0] res_rd,
    output logic                    illegal
`ifdef DBG_READ_EN
    ,
    input  logic [$clog2(NREG)-1:0] dbg_sel,
    output logic [REG_W-1:0]        dbg_data
`endif
);

    localparam int IDX_W = $clog2(NREG);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUBI = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2:0]         r_op;
    logic [IDX_W-1:0]   r_rd;
    logic [IDX_W-1:0]   r_rs1;
    logic [IDX_W-1:0]   r_rs2;
    logic [OPND_W-1:0]  r_imm;
    logic [REG_W-1:0]   r_regs [NREG];

    logic [OPND_W-1:0]  r_alu_a;
    logic [OPND_W-1:0]  r_alu_b;
    logic [2:0]         r_alu_opcode;
    logic               r_res_valid;
    logic [REG_W-1:0]   r_res_data;
    logic [IDX_W-1:0]   r_res_rd;
    logic               r_illegal;

    logic               w_ready;
    logic               w_accept;
    logic               w_decode;
    logic               w_drop;
    logic               w_capture;
    logic               w_wb;
    logic               w_alu_op;
    logic               w_imm_op;
    logic [REG_W-1:0]   w_imm_zx;
    logic [REG_W-1:0]   w_result;
    logic               w_unused;

    // instr[7:6] carry no meaning
    assign w_unused = &{1'b0, instr[7:6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_decode    = 1'b0;
        w_drop      = 1'b0;
        w_capture   = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = rst_n;
                if (instr_valid && rst_n) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_decode = 1'b1;
                if (r_op > OP_CLR) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = S_WB;
            end
            S_WB: begin
                w_wb        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_alu_op = (r_op >= OP_ADD) && (r_op <= OP_SUBI);
    assign w_imm_op = (r_op == OP_ADDI) || (r_op == OP_SUBI);
    assign w_imm_zx = {{(REG_W-OPND_W){1'b0}}, r_imm};

    always_comb begin
        w_result = alu_res;
        case (r_op)
            OP_LOAD: w_result = w_imm_zx;
            OP_CLR:  w_result = '0;
            default: w_result = alu_res;
        endcase
    end

    // Non-ALU ops park the ALU on opcode 000 so its output is a harmless zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_imm        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_rd     <= '0;
            r_illegal    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_res_valid <= w_capture;
            r_illegal   <= w_drop;
            if (w_accept) begin
                r_op  <= instr[16:14];
                r_rd  <= instr[13:12];
                r_rs1 <= instr[11:10];
                r_rs2 <= instr[9:8];
                r_imm <= instr[5:0];
            end
            if (w_decode) begin
                r_alu_a      <= r_regs[r_rs1][OPND_W-1:0];
                r_alu_b      <= w_imm_op ? r_imm : r_regs[r_rs2][OPND_W-1:0];
                r_alu_opcode <= w_alu_op ? r_op : OP_LOAD;
            end
            if (w_capture) begin
                r_res_data <= w_result;
                r_res_rd   <= r_rd;
            end
            if (w_wb) begin
                r_regs[r_res_rd] <= r_res_data;
            end
        end
    end

    assign instr_ready = w_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_opcode  = r_alu_opcode;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_rd      = r_res_rd;
    assign illegal     = r_illegal;

`ifdef DBG_READ_EN
    assign dbg_data = r_regs[dbg_sel];
`endif

endmodule
